// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration slice: data word, RAM handshake
// states and arbiter FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   // A hung or failed access is released the same way as a RAM-reported error.
   function automatic logic is_fault(input ramstate_t rs, input logic expire);
      return (rs == ERROR) || expire;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT-th cycle so a hung RAM access can be forcibly released.
module arb_watchdog #(
   parameter int TIMEOUT = 64
)(
   input  logic CLK,
   input  logic nRST,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] ONE   = TW'(1);

   logic [TW-1:0] timer_r;

   assign expire = enable && (timer_r == LIMIT);

   // Cycle counter, held at the limit so it cannot wrap before the FSM leaves the grant.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         timer_r <= '0;
      end else if (clear) begin
         timer_r <= '0;
      end else if (enable && (timer_r != LIMIT)) begin
         timer_r <= timer_r + ONE;
      end else begin
         timer_r <= timer_r;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache with a bus watchdog.
// Define ARB_FAIR_EN to alternate grants under contention (default: dcache priority).
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int    TIMEOUT  = 64,
   parameter word_t ERR_WORD = 32'hBAD1BAD1
)(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      arb_err
);

   arb_state_t state_r, state_s;
   logic       expire_s;
   logic       err_set_s;
   logic       i_first_s;
   logic       in_idle_s;
   logic       in_grant_s;
`ifdef ARB_FAIR_EN
   logic       last_d_r, last_d_s;
`endif

   assign in_idle_s  = (state_r == IDLE);
   assign in_grant_s = (state_r != IDLE);

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .CLK    (CLK),
      .nRST   (nRST),
      .clear  (in_idle_s),
      .enable (in_grant_s),
      .expire (expire_s)
   );

   // State, sticky error flag and (when fair) the last served requester.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_r  <= IDLE;
         arb_err  <= 1'b0;
`ifdef ARB_FAIR_EN
         last_d_r <= 1'b0;
`endif
      end else begin
         state_r  <= state_s;
         arb_err  <= arb_err | err_set_s;
`ifdef ARB_FAIR_EN
         last_d_r <= last_d_s;
`endif
      end
   end

   // Icache jumps the queue only when dcache was served last and icache is waiting.
   always_comb begin
`ifdef ARB_FAIR_EN
      i_first_s = last_d_r & iREN;
`else
      i_first_s = 1'b0;
`endif
   end

   // Next-state and RAM/cache outputs, all decoded from the current state.
   always_comb begin
      state_s   = state_r;
      err_set_s = 1'b0;
      iwait     = 1'b1;
      dwait     = 1'b1;
      iload     = 32'h0000_0000;
      dload     = 32'h0000_0000;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = 32'h0000_0000;
      ramstore  = 32'h0000_0000;
`ifdef ARB_FAIR_EN
      last_d_s  = last_d_r;
`endif
      case (state_r)
         IDLE: begin
            if (i_first_s) begin
               state_s = IGRANT;
            end else if (dREN || dWEN) begin
               state_s = DGRANT;
            end else if (iREN) begin
               state_s = IGRANT;
            end else begin
               state_s = IDLE;
            end
         end
         IGRANT: begin
            if (!iREN) begin
               state_s = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == ACCESS) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  state_s = IDLE;
`ifdef ARB_FAIR_EN
                  last_d_s = 1'b0;
`endif
               end else if (is_fault(ramstate, expire_s)) begin
                  iwait     = 1'b0;
                  iload     = ERR_WORD;
                  err_set_s = 1'b1;
                  state_s   = IDLE;
`ifdef ARB_FAIR_EN
                  last_d_s  = 1'b0;
`endif
               end else begin
                  state_s = IGRANT;
               end
            end
         end
         DGRANT: begin
            if (!(dREN || dWEN)) begin
               state_s = IDLE;
            end else begin
               // A simultaneous read and write is issued as the write.
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (ramstate == ACCESS) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  state_s = IDLE;
`ifdef ARB_FAIR_EN
                  last_d_s = 1'b1;
`endif
               end else if (is_fault(ramstate, expire_s)) begin
                  dwait     = 1'b0;
                  dload     = ERR_WORD;
                  err_set_s = 1'b1;
                  state_s   = IDLE;
`ifdef ARB_FAIR_EN
                  last_d_s  = 1'b1;
`endif
               end else begin
                  state_s = DGRANT;
               end
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected load words,
// a negedge monitor pops them whenever a wait line drops.
module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore, ramload;
   logic      iwait, dwait, ramREN, ramWEN, arb_err;
   word_t     iload, dload, ramaddr, ramstore;
   ramstate_t ramstate;

   int    checks = 0;
   int    errors = 0;
   word_t iq[$];
   word_t dq[$];

   always #5 CLK = ~CLK;

   cache_mem_arbiter #(.TIMEOUT(8), .ERR_WORD(32'hBAD1BAD1)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: every released wait must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (nRST === 1'b1) begin
         if (iwait !== 1'b1) begin
            if (iq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL iwait_unexpected: got iwait=%b iload=%h expected iwait=1", iwait, iload);
            end else begin
               chk("iload", iload, iq.pop_front());
            end
         end
         if (dwait !== 1'b1) begin
            if (dq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dwait_unexpected: got dwait=%b dload=%h expected dwait=1", dwait, dload);
            end else begin
               chk("dload", dload, dq.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
      ramstate = FREE;
      step(); step();
      @(negedge CLK);
      chk("rst_iwait", {31'h0, iwait}, 32'h1);
      chk("rst_dwait", {31'h0, dwait}, 32'h1);
      chk("rst_ramREN", {31'h0, ramREN}, 32'h0);
      chk("rst_ramWEN", {31'h0, ramWEN}, 32'h0);
      chk("rst_ramaddr", ramaddr, 32'h0);
      chk("rst_arb_err", {31'h0, arb_err}, 32'h0);
      step();
      nRST = 1'b1;
      step();

      // 1: icache read, two BUSY cycles then ACCESS.
      iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
      step();
      @(negedge CLK);
      chk("t1_ramREN", {31'h0, ramREN}, 32'h1);
      chk("t1_ramaddr", ramaddr, 32'h40);
      step();
      ramstate = ACCESS; ramload = 32'h8C010004;
      iq.push_back(32'h8C010004);
      step();
      iREN = 1'b0; ramstate = FREE;
      step();

      // 2: dcache write and icache read together, dcache first.
      dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
      step();
      @(negedge CLK);
      chk("t2_ramWEN", {31'h0, ramWEN}, 32'h1);
      chk("t2_ramREN", {31'h0, ramREN}, 32'h0);
      chk("t2_ramaddr", ramaddr, 32'h100);
      chk("t2_ramstore", ramstore, 32'hDEADBEEF);
      step();
      ramstate = ACCESS; ramload = 32'h0;
      dq.push_back(32'h0);
      step();
      dWEN = 1'b0; ramstate = BUSY;
      @(negedge CLK);
      chk("t2_dead_ramREN", {31'h0, ramREN}, 32'h0);
      chk("t2_dead_ramWEN", {31'h0, ramWEN}, 32'h0);
      step();
      @(negedge CLK);
      chk("t2_i_ramREN", {31'h0, ramREN}, 32'h1);
      chk("t2_i_ramaddr", ramaddr, 32'h80);
      step();
      ramstate = ACCESS; ramload = 32'h11112222;
      iq.push_back(32'h11112222);
      step();
      iREN = 1'b0; ramstate = FREE;
      step();

      // 3: continuous contention; RAM answers at once.
      dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
      ramstate = ACCESS; ramload = 32'h33334444;
`ifdef ARB_FAIR_EN
      dq.push_back(32'h33334444); iq.push_back(32'h33334444);
      dq.push_back(32'h33334444); iq.push_back(32'h33334444);
`else
      for (int k = 0; k < 4; k++) dq.push_back(32'h33334444);
`endif
      for (int k = 0; k < 8; k++) step();
      dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
      step();
      chk("t3_iq_empty", iq.size(), 32'h0);
      chk("t3_dq_empty", dq.size(), 32'h0);

      // 4: RAM stuck BUSY, watchdog releases on the 8th grant cycle.
      dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
      for (int k = 0; k < 7; k++) step();
      @(negedge CLK);
      chk("t4_err_before", {31'h0, arb_err}, 32'h0);
      step();
      dq.push_back(32'hBAD1BAD1);
      step();
      dREN = 1'b0; ramstate = FREE;
      @(negedge CLK);
      chk("t4_arb_err", {31'h0, arb_err}, 32'h1);
      step(); step();

      // 4b: RAM reports ERROR on the first icache grant cycle.
      iREN = 1'b1; iaddr = 32'h700; ramstate = ERROR;
      step();
      iq.push_back(32'hBAD1BAD1);
      step();
      iREN = 1'b0; ramstate = FREE;
      @(negedge CLK);
      chk("t4b_arb_err", {31'h0, arb_err}, 32'h1);
      step();

      // 5: reset in the middle of a dcache write.
      dWEN = 1'b1; daddr = 32'h500; dstore = 32'h1; ramstate = BUSY;
      step();
      @(negedge CLK);
      chk("t5_ramWEN_pre", {31'h0, ramWEN}, 32'h1);
      step();
      nRST = 1'b0;
      step();
      nRST = 1'b1; dWEN = 1'b0;
      @(negedge CLK);
      chk("t5_ramWEN", {31'h0, ramWEN}, 32'h0);
      chk("t5_iwait", {31'h0, iwait}, 32'h1);
      chk("t5_dwait", {31'h0, dwait}, 32'h1);
      chk("t5_arb_err", {31'h0, arb_err}, 32'h0);
      step();

      // 6: dcache read dropped before ACCESS, icache waits for IDLE.
      dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
      step();
      @(negedge CLK);
      chk("t6_ramREN_pre", {31'h0, ramREN}, 32'h1);
      step();
      dREN = 1'b0; iREN = 1'b1; iaddr = 32'h640;
      @(negedge CLK);
      chk("t6_abort_ramREN", {31'h0, ramREN}, 32'h0);
      step();
      @(negedge CLK);
      chk("t6_idle_ramREN", {31'h0, ramREN}, 32'h0);
      step();
      @(negedge CLK);
      chk("t6_i_ramaddr", ramaddr, 32'h640);
      step();
      ramstate = ACCESS; ramload = 32'h55556666;
      iq.push_back(32'h55556666);
      step();
      iREN = 1'b0; ramstate = FREE;
      step(); step();

      chk("end_iq_empty", iq.size(), 32'h0);
      chk("end_dq_empty", dq.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
